gap_pool_reader: RTL and testbench

Global-average-pooling stage directly downstream of the layer-6 ReLU6 activation RAM. It sweeps all 16 spatial positions (4x4) of the RAM and accumulates each of the 64 unsigned 8-bit channels. It then emits one 512-bit vector of per-channel averages to the classifier stage through a valid/ready handshake. The block drives the RAM read port (`rd_en`, `rd_addr`) and consumes its registered `d_out`.

---
 rtl/gap_pool_reader_pkg.sv | 20 ++
 rtl/gap_pool_reader_if.sv | 26 ++
 rtl/gap_pool_reader_channel_acc.sv | 35 +++
 rtl/gap_pool_reader.sv | 84 ++++++++
 tb/tb_gap_pool_reader.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/gap_pool_reader_pkg.sv
// Shared constants and FSM encoding for the global-average-pooling reader.
// Sized for the 4x4x64 layer-6 activation RAM.
package gap_pool_reader_pkg;

    localparam int CH         = 64;
    localparam int DW         = 8;
    localparam int DEPTH      = 16;
    localparam int AW         = 7;
    localparam int LOG2_DEPTH = $clog2(DEPTH);
    localparam int ACC_W      = DW + LOG2_DEPTH;
    localparam int VW         = CH * DW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    typedef logic [DW-1:0] chan_t;

endpackage

// File: rtl/gap_pool_reader_if.sv
// Control, RAM read port and output handshake of the pooling reader.
// Output handshake: a transfer happens on any rising edge where out_valid && out_ready; out_data is held stable while out_valid is high.
interface gap_pool_reader_if;
    import gap_pool_reader_pkg::*;

    logic          start;
    logic          busy;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [VW-1:0] d_in;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_data;
    logic          done;

    modport slave (
        input  start, d_in, out_ready,
        output busy, rd_en, rd_addr, out_valid, out_data, done
    );

    modport master (
        output start, d_in, out_ready,
        input  busy, rd_en, rd_addr, out_valid, out_data, done
    );

endinterface

// File: rtl/gap_pool_reader_channel_acc.sv
// One channel accumulator; avg_o is the shifted *next* sum so the top can
// register the final average in the same edge that absorbs the last word.
module gap_channel_acc
    import gap_pool_reader_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr_i,
    input  logic  en_i,
    input  chan_t din_i,
    output chan_t avg_o
);

    logic [ACC_W-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + {{LOG2_DEPTH{1'b0}}, din_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign avg_o = acc_d[ACC_W-1:LOG2_DEPTH];

endmodule

// File: rtl/gap_pool_reader.sv
// Sweeps the activation RAM, accumulates every channel, and hands one
// vector of floor averages to the classifier over a valid/ready handshake.
module gap_pool_reader
    import gap_pool_reader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    gap_pool_reader_if.slave   bus,
    output logic [1:0]         state_o
);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          cap_q;
    logic [VW-1:0] out_q;
    logic [VW-1:0] avg;
    logic          clr;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    clr     = 1'b1;
                    addr_d  = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (addr_q == AW'(DEPTH - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            S_DRAIN: state_d = S_OUT;
            S_OUT: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // cap_q marks the cycle the registered RAM data belongs to this sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cap_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cap_q   <= (state_q == S_READ);
            if (state_q == S_DRAIN) begin
                out_q <= avg;
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        gap_channel_acc u_acc (
            .clk   (clk),
            .rst   (rst),
            .clr_i (clr),
            .en_i  (cap_q),
            .din_i (bus.d_in[c*DW +: DW]),
            .avg_o (avg[c*DW +: DW])
        );
    end

    assign bus.rd_en     = (state_q == S_READ);
    assign bus.rd_addr   = addr_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out_data  = out_q;
    assign bus.done      = (state_q == S_OUT) && bus.out_ready;
    assign state_o       = state_q;

endmodule

// File: tb/tb_gap_pool_reader.sv
// Directed bench for gap_pool_reader: RAM model, expected-result queue and
// an output monitor that checks every handshake against it.
module tb_gap_pool_reader;
    import gap_pool_reader_pkg::*;

    logic       clk;
    logic       rst;
    logic [1:0] state_o;

    gap_pool_reader_if bus();

    gap_pool_reader dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    // RAM model with one-cycle registered read
    logic [VW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.rd_en) bus.d_in <= mem[bus.rd_addr[LOG2_DEPTH-1:0]];
    end

    int pass_cnt = 0;
    int total_cnt = 0;
    int rd_cnt = 0;
    logic [VW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.rd_en) rd_cnt++;
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_output: got %0h expected no output", bus.out_data);
                end else begin
                    chk("out_data", bus.out_data, exp_q.pop_front());
                end
                chk("done_on_hs", VW'(bus.done), VW'(1));
            end else if (bus.done) begin
                total_cnt++;
                $display("FAIL spurious_done: got 1 expected 0");
            end
        end
    end

    function automatic logic [VW-1:0] fill(input logic [7:0] b);
        logic [VW-1:0] v;
        for (int c = 0; c < CH; c++) v[c*DW +: DW] = b;
        return v;
    endfunction

    task automatic load_const(input logic [7:0] b);
        for (int p = 0; p < DEPTH; p++) mem[p] = fill(b);
    endtask

    task automatic load_ramp();
        for (int p = 0; p < DEPTH; p++)
            for (int c = 0; c < CH; c++) mem[p][c*DW +: DW] = 8'(c + p);
    endtask

    task automatic load_floor();
        for (int p = 0; p < DEPTH; p++) begin
            mem[p] = fill(8'h10);
            mem[p][7:0] = (p == 0) ? 8'd15 : 8'd0;
        end
    endtask

    function automatic logic [VW-1:0] exp_ramp();
        logic [VW-1:0] v;
        for (int c = 0; c < CH; c++) v[c*DW +: DW] = 8'(c + 7);
        return v;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, VW'(bus.busy), '0);
        chk({tag, "_rd_en"}, VW'(bus.rd_en), '0);
        chk({tag, "_rd_addr"}, VW'(bus.rd_addr), '0);
        chk({tag, "_out_valid"}, VW'(bus.out_valid), '0);
        chk({tag, "_out_data"}, bus.out_data, '0);
        chk({tag, "_done"}, VW'(bus.done), '0);
        chk({tag, "_state"}, VW'(state_o), VW'(S_IDLE));
    endtask

    // One pooling pass launched now; rst_at >= 0 aborts it with reset in T+rst_at.
    task automatic do_pass(input string tag, input logic [VW-1:0] exp, input int stall,
                           input bit hold3, input int rst_at);
        int lat = -1;
        bit finished = 1'b0;
        logic [VW-1:0] held = '0;
        if (rst_at < 0) exp_q.push_back(exp);
        rd_cnt = 0;
        bus.start = 1'b1;
        bus.out_ready = (stall == 0);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (n == 0) chk({tag, "_busy_before"}, VW'(bus.busy), '0);
            if (n == 1) begin
                chk({tag, "_first_rd_en"}, VW'(bus.rd_en), VW'(1));
                chk({tag, "_first_addr"}, VW'(bus.rd_addr), '0);
                chk({tag, "_busy_t1"}, VW'(bus.busy), VW'(1));
            end
            if (n == 16 && rst_at < 0) chk({tag, "_last_addr"}, VW'(bus.rd_addr), VW'(15));
            if (n == 17 && rst_at < 0) chk({tag, "_rd_en_drain"}, VW'(bus.rd_en), '0);
            if (rst_at >= 0 && n == rst_at + 1) begin
                chk_reset_outputs({tag, "_rst"});
                @(posedge clk); #2;
                rst = 1'b0;
                finished = 1'b1;
                break;
            end
            if (bus.out_valid && lat < 0) begin
                lat = n;
                held = bus.out_data;
                chk({tag, "_latency"}, VW'(lat), VW'(18));
            end
            if (lat >= 0 && n < lat + stall) begin
                chk({tag, "_stall_done"}, VW'(bus.done), '0);
                chk({tag, "_stall_rd_en"}, VW'(bus.rd_en), '0);
                if (n > lat) chk({tag, "_stall_stable"}, bus.out_data, held);
            end
            if (bus.out_valid && bus.out_ready) begin
                @(posedge clk); #2;
                bus.start = 1'b0;
                finished = 1'b1;
                break;
            end
            @(posedge clk); #2;
            bus.start = (hold3 && n < 2) ||
                        (stall > 0 && lat >= 0 && n + 1 < lat + stall && (n % 2 == 1));
            bus.out_ready = (stall == 0) || (lat >= 0 && n + 1 >= lat + stall);
            if (rst_at >= 0 && n == rst_at - 1) rst = 1'b1;
        end
        if (!finished) begin
            total_cnt++;
            $display("FAIL %s_timeout: got no handshake expected handshake", tag);
        end
        if (rst_at < 0) chk({tag, "_rd_count"}, VW'(rd_cnt), VW'(16));
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        bus.d_in = '0;
        repeat (3) @(posedge clk);
        #2;
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        load_const(8'h06);
        do_pass("const06", fill(8'h06), 0, 1'b0, -1);
        load_ramp();
        do_pass("ramp", exp_ramp(), 0, 1'b0, -1);
        load_const(8'hFF);
        do_pass("allff", fill(8'hFF), 0, 1'b0, -1);
        load_floor();
        do_pass("floor", {fill(8'h10)} & ~VW'(8'hFF), 0, 1'b0, -1);

        // stalled handshake, then a back-to-back pass with different data
        load_const(8'h33);
        do_pass("stall", fill(8'h33), 5, 1'b0, -1);
        load_ramp();
        do_pass("b2b", exp_ramp(), 0, 1'b0, -1);

        // abort mid-READ, then a clean pass must not carry partial sums
        load_const(8'hFF);
        do_pass("abort", '0, 0, 1'b0, 8);
        rd_cnt = 0;
        repeat (25) @(posedge clk);
        #2;
        chk("abort_no_reads", VW'(rd_cnt), '0);
        load_const(8'h06);
        do_pass("after_rst", fill(8'h06), 0, 1'b0, -1);

        // start held for three cycles gives exactly one pass
        load_ramp();
        do_pass("hold3", exp_ramp(), 0, 1'b1, -1);
        repeat (6) @(posedge clk);
        #2;
        chk("hold3_no_rerun", VW'(rd_cnt), VW'(16));

        repeat (4) @(posedge clk);
        #2;
        chk("queue_empty", VW'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
